bcd_xs3_serial_conv: RTL
========================

BCD_XS3_SERIAL_CONV -- requirements
Module: bcd_xs3_serial_conv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of 4-bit digits per word; the legal range is 1..16.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  the input word is valid.
REQ-006 in_ready  output  1  the block can accept a word.
REQ-007 in_data  input  4*DIGITS  packed digits; digit 0 is in bits [3:0].
REQ-008 in_mode  input  1  0 = BCD->Excess-3; 1 = Excess-3->BCD.
REQ-009 out_valid  output  1  the result word is valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 out_data  output  4*DIGITS  converted packed digits.
REQ-012 out_err  output  1  at least one input digit was illegal.
REQ-013 out_err_mask  output  DIGITS  per-digit illegal flags; bit i corresponds to digit i.

Function
REQ-014 The FSM SHALL have three states: IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, an input handshake (in_valid=1 at a rising edge) SHALL capture in_data and in_mode, clear the digit counter to 0, clear the error flags, and enter CONV.
REQ-016 In CONV, each rising edge SHALL convert digit[counter] in place, digit 0 first, and increment the counter.
REQ-017 When the edge converts digit DIGITS-1, the FSM SHALL enter DONE; out_valid SHALL therefore rise exactly DIGITS cycles after the accept edge.
REQ-018 Mode 0 SHALL compute out digit = (in digit + 3) mod 16; mode 1 SHALL compute out digit = (in digit - 3) mod 16.
REQ-019 Digit arithmetic SHALL be 4-bit with no carry between digits.
REQ-020 Mode SHALL be the value captured at the accept edge; in_mode and in_data changes after acceptance SHALL have no effect.
REQ-021 In DONE, out_valid SHALL be 1, and out_data, out_err and out_err_mask SHALL be held stable until out_ready=1 at a rising edge.
REQ-022 The output handshake edge SHALL return the FSM to IDLE; in_ready SHALL be 1 the following cycle.
REQ-023 The block SHALL NOT accept input in the same cycle as the output handshake; minimum throughput is one word per DIGITS+2 cycles.
REQ-024 Illegal input digits SHALL still be converted per REQ-018; no digit is skipped or saturated.
REQ-025 out_data SHALL be don't-care-free: outside DONE it holds the partially converted working register.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, the working register to 0, out_valid=0, out_err=0 and out_err_mask=0.
REQ-027 Reset mid-CONV or mid-DONE SHALL discard the word; no out_valid pulse is produced for it.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 from the first cycle onward.

Configuration
REQ-029 Macro BCD_XS3_ERRCHK_EN SHALL control illegal-digit checking.
REQ-030 With BCD_XS3_ERRCHK_EN defined, a digit SHALL be flagged illegal when it is >9 in mode 0, or when it is <3 or >12 in mode 1.
REQ-031 With BCD_XS3_ERRCHK_EN defined, illegal flags SHALL be set in out_err_mask[counter] during CONV, and out_err SHALL be the OR of out_err_mask.
REQ-032 Without BCD_XS3_ERRCHK_EN, out_err and out_err_mask SHALL be constant 0 and no checking logic SHALL be synthesised; conversion is unchanged.

Verification
REQ-033 The bench SHALL cover the following directed scenarios, with DIGITS=4:
- Mode 0, in_data=16'h1234 -> out_data=16'h4567, out_valid rises 4 cycles after the accept edge, out_err=0.
- Mode 0, in_data=16'h9990 -> out_data=16'hCCC3.
- Mode 1, in_data=16'h4567 -> out_data=16'h1234.
- Mode 1, in_data=16'hC3C3 -> out_data=16'h9090.
- With ERRCHK, mode 0, in_data=16'h12A4 -> out_data=16'h45D7, out_err=1, out_err_mask=4'b0010.
- Without ERRCHK, the same stimulus -> identical out_data, with out_err=0 and out_err_mask=0.
- out_ready held low 6 cycles in DONE -> out_data stable, in_ready=0, and a new in_valid is ignored; on release, exactly one output handshake occurs.
- rst_n pulsed low at CONV counter=2 -> out_valid never asserts for that word, in_ready=1 after reset, and the next word 16'h0000 (mode 0) -> 16'h3333.

Source files
------------

// File: rtl/bcd_xs3_serial_conv.sv
// Serial BCD <-> Excess-3 converter: one 4-bit digit per clock, digit 0 first.
// Optional illegal-digit checking is enabled by defining BCD_XS3_ERRCHK_EN.
module bcd_xs3_serial_conv #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic [1:0]            dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is 1 only in IDLE and out_valid only in DONE, so the two never coincide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    data_q;
  logic            mode_q;
  logic [3:0]      cur_digit;
  logic [3:0]      new_digit;
  logic            last_digit;

  always_comb begin
    cur_digit  = data_q[4*cnt_q +: 4];
    new_digit  = mode_q ? (cur_digit - 4'd3) : (cur_digit + 4'd3);
    last_digit = (cnt_q == CW'(DIGITS - 1));
  end

`ifdef BCD_XS3_ERRCHK_EN
  logic [DIGITS-1:0] mask_q;
  logic              illegal;

  always_comb begin
    illegal = mode_q ? ((cur_digit < 4'd3) || (cur_digit > 4'd12)) : (cur_digit > 4'd9);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
`ifdef BCD_XS3_ERRCHK_EN
      mask_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            cnt_q   <= '0;
`ifdef BCD_XS3_ERRCHK_EN
            mask_q  <= '0;
`endif
            state_q <= CONV;
          end
        end
        CONV: begin
          data_q[4*cnt_q +: 4] <= new_digit;
`ifdef BCD_XS3_ERRCHK_EN
          mask_q[cnt_q]        <= illegal;
`endif
          cnt_q <= cnt_q + 1'b1;
          if (last_digit) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign dbg_state = state_q;

`ifdef BCD_XS3_ERRCHK_EN
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;
`else
  assign out_err_mask = '0;
  assign out_err      = 1'b0;
`endif

endmodule
